// File: rtl/kpad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package kpad_pkg;

    typedef enum logic [1:0] {
        Scan     = 2'd0,
        Debounce = 2'd1,
        Held     = 2'd2,
        Release  = 2'd3
    } kpad_state_e;

    localparam logic [3:0] COL_FIRST = 4'b0001;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/kpad_sync.sv
// Two-flop synchronizer for asynchronous level inputs; resets to zero.
module kpad_sync #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/kpad_scanner.sv
// 4x4 keypad scanner: column drive, row debounce and one strobe per accepted press.
module kpad_scanner
    import kpad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       enable
);

    localparam int unsigned CntMax = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                                     : DEBOUNCE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_CYCLES - 1);
    localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);

    logic [3:0] row_s;

    kpad_sync #(
        .Width (4)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (row_in),
        .q_o    (row_s)
    );

    kpad_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      col_drive_q, col_drive_d;
    logic [3:0]      row_q, row_d;
    logic [3:0]      col_q, col_d;
    logic            enable_q, enable_d;

    logic [3:0] col_next;
    logic       row_hit;

    assign col_next = {col_drive_q[2:0], col_drive_q[3]};
    // Only the latched row bit matters once held; other same-column keys are masked.
    assign row_hit  = |(row_s & row_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_drive_d = col_drive_q;
        row_d       = row_q;
        col_d       = col_q;
        enable_d    = 1'b0;

        case (state_q)
            Scan: begin
                if (cnt_q == ScanLast) begin
                    cnt_d = '0;
                    if (is_onehot(row_s)) begin
                        row_d   = row_s;
                        col_d   = col_drive_q;
                        state_d = Debounce;
                    end else begin
                        col_drive_d = col_next;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            Debounce: begin
                if (row_s != row_q) begin
                    state_d     = Scan;
                    cnt_d       = '0;
                    col_drive_d = col_next;
                end else if (cnt_q == DebLast) begin
                    state_d  = Held;
                    cnt_d    = '0;
                    enable_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            Held: begin
                if (!row_hit) begin
                    state_d = Release;
                    cnt_d   = '0;
                end
            end
            Release: begin
                if (row_hit) begin
                    state_d = Held;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d     = Scan;
                    cnt_d       = '0;
                    col_drive_d = col_next;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = Scan;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= Scan;
            cnt_q       <= '0;
            col_drive_q <= COL_FIRST;
            row_q       <= 4'd0;
            col_q       <= 4'd0;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_drive_q <= col_drive_d;
            row_q       <= row_d;
            col_q       <= col_d;
            enable_q    <= enable_d;
        end
    end

    assign col_drive = col_drive_q;
    assign row       = row_q;
    assign col       = col_q;
    assign enable    = enable_q;

endmodule

// File: tb/tb_kpad_scanner.sv
// Directed bench for kpad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8 and a keypad model.
module tb_kpad_scanner;
    import kpad_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [3:0] row;
    logic [3:0] col;
    logic       enable;

    // Key index = row*4 + col; a key drives its row only while its column is driven.
    logic [15:0] keys;

    assign row_in = {|(keys[15:12] & col_drive), |(keys[11:8] & col_drive),
                     |(keys[7:4] & col_drive),   |(keys[3:0] & col_drive)};

    kpad_scanner #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_drive (col_drive),
        .row       (row),
        .col       (col),
        .enable    (enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        int unsigned cyc;
        logic [15:0] keys;
        logic [3:0]  cd;
        logic [3:0]  row;
        logic [3:0]  col;
        logic        en;
        int unsigned nen;
    } vec_t;

    localparam logic [15:0] K0 = 16'h0000;
    localparam logic [15:0] K1 = 16'h0001;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K9 = 16'h0400;

    vec_t        vecs[$];
    vec_t        v;
    int unsigned cyc;
    int unsigned en_cnt;
    int          checks;
    int          errors;

    function automatic vec_t mk(int unsigned c, logic [15:0] k, logic [3:0] cd, logic [3:0] r,
                                logic [3:0] co, logic e, int unsigned n);
        vec_t t;
        t.rst = 1'b0; t.cyc = c; t.keys = k; t.cd = cd; t.row = r; t.col = co;
        t.en = e; t.nen = n;
        return t;
    endfunction

    function automatic vec_t mk_rst(logic [15:0] k);
        vec_t t;
        t = mk(0, k, 4'd0, 4'd0, 4'd0, 1'b0, 0);
        t.rst = 1'b1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (enable) begin
            en_cnt++;
            chk("strobe_onehot", {31'd0, is_onehot(row) && is_onehot(col)}, 32'd1);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_col_drive"}, {28'd0, col_drive}, {28'd0, COL_FIRST});
        chk({tag, "_row"}, {28'd0, row}, 32'd0);
        chk({tag, "_col"}, {28'd0, col}, 32'd0);
        chk({tag, "_enable"}, {31'd0, enable}, 32'd0);
    endtask

    task automatic do_reset(input logic [15:0] k);
        @(negedge clk);
        reset = 1'b0;
        keys  = k;
        @(negedge clk);
        reset  = 1'b1;
        cyc    = 0;
        en_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        en_cnt = 0;
        keys   = K0;
        reset  = 1'b0;

        // Press '5' for 200 cycles, then release.
        vecs.push_back(mk_rst(K5));
        vecs.push_back(mk(3,   K5, 4'h1, 4'h0, 4'h0, 1'b0, 0));
        vecs.push_back(mk(4,   K5, 4'h2, 4'h0, 4'h0, 1'b0, 0));
        vecs.push_back(mk(7,   K5, 4'h2, 4'h0, 4'h0, 1'b0, 0));
        vecs.push_back(mk(8,   K5, 4'h2, 4'h2, 4'h2, 1'b0, 0));
        vecs.push_back(mk(15,  K5, 4'h2, 4'h2, 4'h2, 1'b0, 0));
        vecs.push_back(mk(16,  K5, 4'h2, 4'h2, 4'h2, 1'b1, 1));
        vecs.push_back(mk(17,  K5, 4'h2, 4'h2, 4'h2, 1'b0, 1));
        vecs.push_back(mk(200, K0, 4'h2, 4'h2, 4'h2, 1'b0, 1));
        vecs.push_back(mk(210, K0, 4'h2, 4'h2, 4'h2, 1'b0, 1));
        vecs.push_back(mk(211, K0, 4'h4, 4'h2, 4'h2, 1'b0, 1));
        vecs.push_back(mk(214, K0, 4'h4, 4'h2, 4'h2, 1'b0, 1));
        vecs.push_back(mk(215, K0, 4'h8, 4'h2, 4'h2, 1'b0, 1));
        // Bounce on press: key drops during debounce.
        vecs.push_back(mk_rst(K5));
        vecs.push_back(mk(8,  K5, 4'h2, 4'h2, 4'h2, 1'b0, 0));
        vecs.push_back(mk(10, K0, 4'h2, 4'h2, 4'h2, 1'b0, 0));
        vecs.push_back(mk(12, K0, 4'h2, 4'h2, 4'h2, 1'b0, 0));
        vecs.push_back(mk(13, K0, 4'h4, 4'h2, 4'h2, 1'b0, 0));
        vecs.push_back(mk(17, K0, 4'h8, 4'h2, 4'h2, 1'b0, 0));
        vecs.push_back(mk(30, K0, 4'h4, 4'h2, 4'h2, 1'b0, 0));
        // Bounce on release, then a full release.
        vecs.push_back(mk_rst(K5));
        vecs.push_back(mk(16, K5, 4'h2, 4'h2, 4'h2, 1'b1, 1));
        vecs.push_back(mk(30, K0, 4'h2, 4'h2, 4'h2, 1'b0, 1));
        vecs.push_back(mk(33, K5, 4'h2, 4'h2, 4'h2, 1'b0, 1));
        vecs.push_back(mk(60, K0, 4'h2, 4'h2, 4'h2, 1'b0, 1));
        vecs.push_back(mk(70, K0, 4'h2, 4'h2, 4'h2, 1'b0, 1));
        vecs.push_back(mk(71, K0, 4'h4, 4'h2, 4'h2, 1'b0, 1));
        vecs.push_back(mk(75, K0, 4'h8, 4'h2, 4'h2, 1'b0, 1));
        // Two keys in column 0 (rows 0011) are never accepted.
        vecs.push_back(mk_rst(16'h0011));
        vecs.push_back(mk(4,  16'h0011, 4'h2, 4'h0, 4'h0, 1'b0, 0));
        vecs.push_back(mk(20, 16'h0011, 4'h2, 4'h0, 4'h0, 1'b0, 0));
        vecs.push_back(mk(40, 16'h0011, 4'h4, 4'h0, 4'h0, 1'b0, 0));
        // Hold '1', press '9'; '9' is accepted only after '1' releases.
        vecs.push_back(mk_rst(K1));
        vecs.push_back(mk(4,  K1,      4'h1, 4'h1, 4'h1, 1'b0, 0));
        vecs.push_back(mk(11, K1,      4'h1, 4'h1, 4'h1, 1'b0, 0));
        vecs.push_back(mk(12, K1,      4'h1, 4'h1, 4'h1, 1'b1, 1));
        vecs.push_back(mk(20, K1 | K9, 4'h1, 4'h1, 4'h1, 1'b0, 1));
        vecs.push_back(mk(60, K9,      4'h1, 4'h1, 4'h1, 1'b0, 1));
        vecs.push_back(mk(70, K9,      4'h1, 4'h1, 4'h1, 1'b0, 1));
        vecs.push_back(mk(71, K9,      4'h2, 4'h1, 4'h1, 1'b0, 1));
        vecs.push_back(mk(75, K9,      4'h4, 4'h1, 4'h1, 1'b0, 1));
        vecs.push_back(mk(78, K9,      4'h4, 4'h1, 4'h1, 1'b0, 1));
        vecs.push_back(mk(79, K9,      4'h4, 4'h4, 4'h4, 1'b0, 1));
        vecs.push_back(mk(86, K9,      4'h4, 4'h4, 4'h4, 1'b0, 1));
        vecs.push_back(mk(87, K9,      4'h4, 4'h4, 4'h4, 1'b1, 2));
        vecs.push_back(mk(88, K0,      4'h4, 4'h4, 4'h4, 1'b0, 2));

        // Reset values, then a reset pulse mid-scan.
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b1;
        repeat (6) tick();
        chk("midscan_col_drive", {28'd0, col_drive}, 32'h2);
        reset = 1'b0;
        #1;
        chk_reset_vals("midscan_rst");
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        repeat (3) tick();
        chk("restart_hold", {28'd0, col_drive}, 32'h1);
        tick();
        chk("restart_step", {28'd0, col_drive}, 32'h2);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) begin
                do_reset(v.keys);
            end else begin
                while (cyc < v.cyc) tick();
                chk($sformatf("v%0d_col_drive", i), {28'd0, col_drive}, {28'd0, v.cd});
                chk($sformatf("v%0d_row", i), {28'd0, row}, {28'd0, v.row});
                chk($sformatf("v%0d_col", i), {28'd0, col}, {28'd0, v.col});
                chk($sformatf("v%0d_enable", i), {31'd0, enable}, {31'd0, v.en});
                chk($sformatf("v%0d_strobes", i), en_cnt, v.nen);
                keys = v.keys;
            end
        end

        // Reset four cycles into debounce discards the press.
        do_reset(K5);
        while (cyc < 12) tick();
        chk("deb_rst_latched_row", {28'd0, row}, 32'h2);
        reset = 1'b0;
        keys  = K0;
        #1;
        chk_reset_vals("deb_rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (40) tick();
        chk("deb_rst_no_strobe", en_cnt, 32'd0);
        chk("deb_rst_row", {28'd0, row}, 32'd0);
        chk("deb_rst_col", {28'd0, col}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kpad_scanner.md
# kpad_scanner

Keypad scanner: drives the 4×4 matrix columns one at a time, synchronizes and debounces the row returns, and reports each new key press as a one-hot row/col pair with a single-cycle `enable` strobe. It sits between the keypad pins and the keypad decoder, supplying that block's `row`, `col` and `enable` inputs. The design registers one key per press; auto-repeat is not supported.

## Interface
- `SCAN_CYCLES`, default 1000: clock cycles each column is driven before it is sampled (≥2).
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a press or a release (≥2).
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `row_in`  in  4  raw row pins, active-high (external pull-downs), asynchronous to `clk`.
- `col_drive`  out  4  one-hot, active-high column drive to the keypad.
- `row`  out  4  one-hot latched row of the accepted key.
- `col`  out  4  one-hot latched column of the accepted key.
- `enable`  out  1  one-cycle strobe marking a new accepted press.

## Operation
- `row_in` passes through a 2-flop synchronizer to produce `row_s`. All decisions use `row_s` only.
- Reset values: `col_drive`=0001, `row`=0000, `col`=0000, `enable`=0, state=SCAN, counters=0.
- SCAN state:
  - `col_drive` rotates 0001→0010→0100→1000→0001, advancing every `SCAN_CYCLES`.
  - `row_s` is sampled on the last dwell cycle of each column.
  - If the sample is exactly one-hot, the block latches `row`←`row_s` and `col`←`col_drive`, freezes `col_drive` and enters DEBOUNCE.
  - A sample of zero or multi-hot (two keys in one column) is ignored and scanning continues.
- DEBOUNCE state:
  - The counter clears on entry and increments each cycle that `row_s`==`row`.
  - Any mismatch returns the block to SCAN, advancing to the next column. `row` and `col` keep their previous latched values; no strobe is issued.
  - After `DEBOUNCE_CYCLES` consecutive matches, the block enters HELD and asserts `enable` for that first HELD cycle only.
- HELD state:
  - `col_drive` stays frozen.
  - The block remains in HELD while (`row_s` & `row`)≠0.
  - Other keys are ignored: other-column keys are undriven, and extra same-column bits are masked.
  - When the latched row bit drops, the block enters RELEASE.
- RELEASE state:
  - The counter clears on entry and counts cycles with the latched bit low.
  - If the bit returns before `DEBOUNCE_CYCLES`, the block goes back to HELD with no strobe.
  - After `DEBOUNCE_CYCLES` low cycles, the block goes to SCAN and resumes at the next column. `row` and `col` keep their values.
- `enable` never asserts outside the DEBOUNCE→HELD transition. Exactly one strobe is issued per accepted press.
- Counter width: $clog2 of max(`SCAN_CYCLES`,`DEBOUNCE_CYCLES`). The counter never wraps: it clears on every state change and on column advance.
- Asserting reset in any state immediately forces the reset values. A press in progress is discarded; no strobe is issued.

## Timing
- Input latency: 2 cycles through the synchronizer.
- Column dwell: exactly `SCAN_CYCLES` cycles. A full sweep takes 4×`SCAN_CYCLES`.
- Press acceptance:
  - DEBOUNCE is entered the cycle after the sampling edge.
  - `enable` is high `DEBOUNCE_CYCLES` cycles after DEBOUNCE entry, for 1 cycle.
  - `row` and `col` are valid from DEBOUNCE entry and stable while `enable` is high.
- Release: scanning resumes `DEBOUNCE_CYCLES` cycles after the last high `row_s` sample.
- All outputs are registered. No combinational path runs from `row_in` to any output.

## Structure
- Package `kpad_pkg`:
  - state enum (`SCAN`, `DEBOUNCE`, `HELD`, `RELEASE`);
  - `COL_FIRST`=4'b0001;
  - a one-hot check function shared with benches.
- Sub-module `kpad_sync`: parameterized-width 2-flop synchronizer with active-low async reset to 0.
- The scanner is one module: the FSM plus one shared counter.

## Test plan
Benches use `SCAN_CYCLES`=4 and `DEBOUNCE_CYCLES`=8. A behavioral keypad model returns the row bit of each pressed key whose column is driven.
- Reset: pulse `reset` low mid-scan → `col_drive`=0001, `row`=`col`=0000, `enable`=0; rotation restarts 4 cycles after release.
- Press '5' (row 0010, col 0010) for 200 cycles:
  - exactly one `enable` pulse, with `row`=0010 and `col`=0010;
  - `col_drive` holds 0010 until release debounce completes, then steps to 0100.
- Bounce on press: assert the key for 3 cycles after sampling, then drop it → no `enable`; scan resumes at the next column.
- Bounce on release: in HELD, drop the key for 3 cycles and restore it → no second `enable`; then a full release → one RELEASE, after which scanning resumes.
- Multiple keys:
  - rows 0011 on the same column at sampling → no `enable`;
  - holding '1' while pressing '9' → no strobe for '9' until '1' releases, then '9' is accepted with `row`=0100, `col`=0100.
- Reset during DEBOUNCE, 4 cycles in → outputs return to reset values; no `enable` ever asserts.
